// File: rtl/apple2e_audio_pkg.sv
// Shared audio types and constants for the I2S transmit path.
//   SAMPLE_W   : width of one signed PCM channel sample
//   FRAME_BITS : bits in one stereo I2S frame (left then right)
//   stereo_t   : one left/right pair, packed with left in the upper half
package apple2e_audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = 5;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_t;

  // Serial bit order of a frame: left MSB first, right LSB last.
  function automatic logic [FRAME_BITS-1:0] frame_of(stereo_t pair);
    return {pair.left, pair.right};
  endfunction

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Sample handshake between an audio source and the I2S transmitter.
//   left, right  : signed sample pair offered by the source
//   sample_valid : pair is offered this cycle
//   sample_ready : transmitter can take the pair this cycle
// A pair moves on any cycle where sample_valid and sample_ready are both high.
interface i2s_audio_tx_if;
  import apple2e_audio_pkg::*;

  logic signed [SAMPLE_W-1:0] left;
  logic signed [SAMPLE_W-1:0] right;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (
    output left,
    output right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left,
    input  right,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: divides clk_sys down to the I2S bit clock.
//   clk_sys : system clock
//   reset   : asynchronous, active-high
//   bck     : bit clock, toggles every BCK_DIV clk_sys cycles
//   fall    : high on the clk_sys cycle whose edge drives bck from 1 to 0
// BCK_DIV must lie in 1..255.
module i2s_bck_gen #(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  output logic bck,
  output logic fall
);

  localparam logic [7:0] DivLast = 8'(BCK_DIV - 1);

  logic [7:0] div_q;
  logic       bck_q;
  logic       wrap;

  assign wrap = (div_q == DivLast);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      bck_q <= 1'b0;
    end else if (wrap) begin
      div_q <= '0;
      bck_q <= ~bck_q;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  assign bck = bck_q;
  // Strobe lines up with the edge that lowers bck, so data moves with it.
  assign fall = wrap & bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter with a one-entry sample buffer.
//   clk_sys  : system clock, all state rising-edge clocked
//   reset    : asynchronous, active-high
//   bus      : sample handshake (slave side)
//   underrun : one-cycle pulse when a frame starts without a fresh pair
//   I2S_BCK  : bit clock, period 2*BCK_DIV clk_sys cycles
//   I2S_LRCK : word select, 0 = left, 1 = right
//   I2S_DATA : serial data, MSB first, one BCK behind LRCK
// A frame is 32 bits; the sample rate is clk_sys / (64*BCK_DIV). When no new
// pair has arrived by the start of a frame, the last pair is replayed.
module i2s_audio_tx
  import apple2e_audio_pkg::*;
#(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic           clk_sys,
  input  logic           reset,
  i2s_audio_tx_if.slave  bus,
  output logic           underrun,
  output logic           I2S_BCK,
  output logic           I2S_LRCK,
  output logic           I2S_DATA
);

  logic                  bck;
  logic                  fall;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic                  lrck_q;
  logic                  data_q;
  logic [FRAME_BITS-1:0] shifter_q;
  stereo_t               last_q;
  stereo_t               buf_q;
  logic                  buf_full_q;
  logic                  underrun_q;
  stereo_t               in_pair;
  logic                  load;
  logic                  accept;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bck     (bck),
    .fall    (fall)
  );

  assign in_pair      = '{left: bus.left, right: bus.right};
  assign bit_cnt_next = bit_cnt_q + 5'd1;
  // Frame start: the falling event that wraps bit_cnt to 0.
  assign load         = fall && (bit_cnt_next == '0);
  // Only possible while empty, so it never collides with a load that drains.
  assign accept       = bus.sample_valid && !buf_full_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= 5'd31;
      lrck_q     <= 1'b1;
      data_q     <= 1'b0;
      shifter_q  <= '0;
      last_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      if (fall) begin
        bit_cnt_q <= bit_cnt_next;
        lrck_q    <= bit_cnt_next[CNT_W-1];
        // At k = 0 this emits the previous frame's last bit (I2S delay).
        data_q    <= shifter_q[FRAME_BITS-1];
        if (load) begin
          if (buf_full_q) begin
            shifter_q <= frame_of(buf_q);
            last_q    <= buf_q;
          end else begin
            shifter_q  <= frame_of(last_q);
            underrun_q <= 1'b1;
          end
        end else begin
          shifter_q <= {shifter_q[FRAME_BITS-2:0], 1'b0};
        end
      end

      // A load that sees an empty buffer does not bypass a same-cycle accept;
      // the new pair waits for the next frame.
      if (load && buf_full_q) begin
        buf_full_q <= 1'b0;
      end else if (accept) begin
        buf_q      <= in_pair;
        buf_full_q <= 1'b1;
      end
    end
  end

  assign bus.sample_ready = ~buf_full_q;
  assign underrun         = underrun_q;
  assign I2S_BCK          = bck;
  assign I2S_LRCK         = lrck_q;
  assign I2S_DATA         = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
module tb_i2s_audio_tx;
  import apple2e_audio_pkg::*;

  localparam int unsigned D = 2;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic underrun, bck, lrck, data;

  i2s_audio_tx_if bus ();

  i2s_audio_tx #(
    .BCK_DIV (D)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .bus      (bus),
    .underrun (underrun),
    .I2S_BCK  (bck),
    .I2S_LRCK (lrck),
    .I2S_DATA (data)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since reset release drives the clocks arithmetically;
  // frame contents follow the hold-buffer / replay rules.
  int unsigned mt;
  int unsigned m_cnt;
  bit          m_full;
  logic [31:0] m_buf, m_last, m_cur;
  logic        m_data, m_under;

  always @(posedge clk_sys or posedge reset) begin : model
    int unsigned n, k;
    bit full_pre, acc;
    if (reset) begin
      mt = 0; m_cnt = 31; m_full = 0; m_buf = 0; m_last = 0; m_cur = 0;
      m_data = 0; m_under = 0;
    end else begin
      full_pre = m_full;
      acc      = bus.sample_valid && !full_pre;
      mt++;
      m_under = 0;
      if (mt % (2 * D) == 0) begin
        n = mt / (2 * D);
        k = (n - 1) % 32;
        m_cnt = k;
        if (k == 0) begin
          m_data = m_cur[0];
          if (full_pre) begin
            m_cur = m_buf; m_last = m_buf; m_full = 0;
          end else begin
            m_cur = m_last; m_under = 1;
          end
        end else begin
          m_data = m_cur[32 - k];
        end
      end
      if (acc) begin
        m_buf  = {bus.left, bus.right};
        m_full = 1;
      end
    end
  end

  // Compare process plus a simple I2S receiver and event counters.
  int          under_cnt = 0;
  int          acc_cnt   = 0;
  logic [31:0] rx_q[$];
  logic [31:0] rx_word = '0;
  bit          rx_have = 0;
  logic        bck_prev = 1'b0;

  always @(negedge clk_sys) begin
    check("bck", 32'(bck), (mt / D) % 2);
    check("lrck", 32'(lrck), 32'(m_cnt >= 16));
    check("data", 32'(data), 32'(m_data));
    check("ready", 32'(bus.sample_ready), 32'(!m_full));
    check("underrun", 32'(underrun), 32'(m_under));
    if (underrun) under_cnt++;
    if (bus.sample_valid && bus.sample_ready) acc_cnt++;
    if (reset) begin
      rx_have = 0;
    end else if (!bck_prev && bck) begin
      if (m_cnt == 0) begin
        if (rx_have) rx_q.push_back({rx_word[31:1], data});
        rx_have = 0;
      end else begin
        rx_word[32 - m_cnt] = data;
        if (m_cnt == 1) rx_have = 1;
      end
    end
    bck_prev = bck;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    step();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    repeat (cycles) step();
    reset = 1'b0;
    under_cnt = 0;
    acc_cnt = 0;
    rx_q.delete();
  endtask

  task automatic wait_t(input int unsigned target);
    for (int i = 0; i < 5000 && mt < target; i++) step();
    check("wait_timeout", 32'(mt >= target), 32'd1);
  endtask

  initial begin
    bus.left = '0;
    bus.right = '0;
    bus.sample_valid = 1'b0;
    repeat (4) step();
    reset = 1'b0;

    // Idle: silence with one underrun per frame.
    wait_t(512);
    check("idle_underruns", 32'(under_cnt), 32'd4);
    check("idle_rx_frames", 32'(rx_q.size() >= 3), 32'd1);
    if (rx_q.size() >= 3) check("idle_frame1", rx_q[1], 32'h0);

    // One pair before the first load, then nothing: it repeats.
    do_reset(3);
    bus.left = 16'h8001; bus.right = 16'h7FFE; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    wait_t(384);
    check("repeat_underruns", 32'(under_cnt), 32'd2);
    check("repeat_rx_frames", 32'(rx_q.size() >= 2), 32'd1);
    if (rx_q.size() >= 2) begin
      check("frame0", rx_q[0], 32'h80017FFE);
      check("frame1_repeat", rx_q[1], 32'h80017FFE);
    end

    // Offer coinciding with a load while empty: underrun, sent one frame later.
    do_reset(3);
    wait_t(131);
    bus.left = 16'h1234; bus.right = 16'hABCD; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    wait_t(400);
    check("coinc_underruns", 32'(under_cnt), 32'd3);
    check("coinc_rx_frames", 32'(rx_q.size() >= 3), 32'd1);
    if (rx_q.size() >= 3) begin
      check("coinc_frame1", rx_q[1], 32'h0);
      check("coinc_frame2", rx_q[2], 32'h1234ABCD);
    end

    // Continuous valid: one accept per frame (plus the initial fill).
    do_reset(3);
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 5000 && mt < 400; i++) begin
      step();
      bus.left = 16'($urandom);
      bus.right = 16'($urandom);
    end
    bus.sample_valid = 1'b0;
    check("stream_accepts", 32'(acc_cnt), 32'd5);
    check("stream_underruns", 32'(under_cnt), 32'd0);

    // Random sparse traffic against the model.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.sample_valid = ($urandom_range(0, 99) < 3);
      bus.left = 16'($urandom);
      bus.right = 16'($urandom);
    end
    bus.sample_valid = 1'b0;

    // Reset mid-frame at bit_cnt 10.
    for (int i = 0; i < 1000 && m_cnt != 10; i++) step();
    check("reach_cnt10", m_cnt, 32'd10);
    reset = 1'b1;
    repeat (3) step();
    check("rst_lrck", 32'(lrck), 32'd1);
    check("rst_ready", 32'(bus.sample_ready), 32'd1);
    reset = 1'b0;
    wait_t(2 * D);
    check("post_rst_lrck", 32'(lrck), 32'd0);
    check("post_rst_underrun", 32'(underrun), 32'd1);
    wait_t(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
